// File: rtl/ibex_instr_realigner.sv
// Realigns word-aligned fetch data into one LSB-aligned RV32/RVC instruction per handshake.
// Optional: define IBEX_REALIGN_ERR_EN to carry fetch bus errors through to the decoder.
module ibex_instr_realigner #(
   parameter logic [31:0] BootAddr = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_valid_i,
   input  logic [31:0] fetch_rdata_i,
   input  logic        fetch_err_i,
   output logic        fetch_ready_o,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_addr_o,
   output logic        out_err_o,
   output logic        out_err_plus2_o
);

   typedef enum logic [1:0] { ALIGNED, STASH, SKIP } state_e;

   state_e      state_q, state_d;
   logic [31:1] pc_q, pc_d;
   logic [15:0] stash_q;
   logic        stash_load, stash_clr;
   logic        stash_err;
   logic        word_err;
   logic        word_fire;
   logic        out_valid, fetch_ready, err, err_plus2;
   logic [31:0] instr;

   function automatic logic is_rvc(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

`ifdef IBEX_REALIGN_ERR_EN
   logic stash_err_q;
   logic unused_addr_bit;

   assign word_err        = fetch_err_i;
   assign stash_err       = stash_err_q;
   assign unused_addr_bit = branch_addr_i[0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)           stash_err_q <= 1'b0;
      else if (stash_clr)  stash_err_q <= 1'b0;
      else if (stash_load) stash_err_q <= fetch_err_i;
   end
`else
   logic unused_inputs;

   assign word_err      = 1'b0;
   assign stash_err     = 1'b0;
   assign unused_inputs = fetch_err_i ^ branch_addr_i[0];
`endif

   assign word_fire = fetch_valid_i & out_ready_i;

   // pc_q counts halfwords: +1 per RVC, +2 per 32-bit instruction
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      stash_load  = 1'b0;
      stash_clr   = 1'b0;
      out_valid   = 1'b0;
      fetch_ready = 1'b0;
      instr       = '0;
      err         = 1'b0;
      err_plus2   = 1'b0;
      if (branch_i) begin
         fetch_ready = 1'b1;
         pc_d        = branch_addr_i[31:1];
         stash_clr   = 1'b1;
         state_d     = branch_addr_i[1] ? SKIP : ALIGNED;
      end else begin
         unique case (state_q)
            ALIGNED: begin
               out_valid   = fetch_valid_i;
               fetch_ready = out_ready_i;
               if (word_err) begin
                  // an erroneous word never seeds the stash
                  instr = fetch_rdata_i;
                  err   = 1'b1;
                  if (word_fire) pc_d = pc_q + 31'd2;
               end else if (is_rvc(fetch_rdata_i[15:0])) begin
                  instr = {16'h0000, fetch_rdata_i[15:0]};
                  if (word_fire) begin
                     stash_load = 1'b1;
                     pc_d       = pc_q + 31'd1;
                     state_d    = STASH;
                  end
               end else begin
                  instr = fetch_rdata_i;
                  if (word_fire) pc_d = pc_q + 31'd2;
               end
            end
            STASH: begin
               if (is_rvc(stash_q)) begin
                  out_valid = 1'b1;
                  instr     = {16'h0000, stash_q};
                  err       = stash_err;
                  if (out_ready_i) begin
                     pc_d    = pc_q + 31'd1;
                     state_d = ALIGNED;
                  end
               end else begin
                  out_valid   = fetch_valid_i;
                  fetch_ready = out_ready_i;
                  instr       = {fetch_rdata_i[15:0], stash_q};
                  err         = stash_err | word_err;
                  err_plus2   = word_err & ~stash_err;
                  if (word_fire) begin
                     stash_load = 1'b1;
                     pc_d       = pc_q + 31'd2;
                  end
               end
            end
            SKIP: begin
               fetch_ready = 1'b1;
               if (fetch_valid_i) begin
                  stash_load = 1'b1;
                  state_d    = STASH;
               end
            end
            default: state_d = ALIGNED;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ALIGNED;
         pc_q    <= BootAddr[31:1];
         stash_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (stash_clr)       stash_q <= '0;
         else if (stash_load) stash_q <= fetch_rdata_i[31:16];
      end
   end

   assign out_valid_o     = ~rst_i & out_valid;
   assign fetch_ready_o   = ~rst_i & fetch_ready;
   assign out_instr_o     = out_valid_o ? instr : '0;
   assign out_err_o       = out_valid_o & err;
   assign out_err_plus2_o = out_valid_o & err_plus2;
   assign out_addr_o      = {pc_q, 1'b0};

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Randomized bench for ibex_instr_realigner against a halfword-queue reference model.
module tb_ibex_instr_realigner;

`ifdef IBEX_REALIGN_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid;
   logic [31:0] fetch_rdata;
   logic        fetch_err;
   logic        fetch_ready;
   logic        branch;
   logic [31:0] branch_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;
   logic        out_err_plus2;

   always #5 clk = ~clk;

   ibex_instr_realigner #(.BootAddr(32'h0000_0080)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .fetch_valid_i   (fetch_valid),
      .fetch_rdata_i   (fetch_rdata),
      .fetch_err_i     (fetch_err),
      .fetch_ready_o   (fetch_ready),
      .branch_i        (branch),
      .branch_addr_i   (branch_addr),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .out_instr_o     (out_instr),
      .out_addr_o      (out_addr),
      .out_err_o       (out_err),
      .out_err_plus2_o (out_err_plus2)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference: pending halfwords (data + error) that start at byte address m_pc.
   typedef struct packed { logic [15:0] d; logic e; } half_t;
   half_t       m_q[$];
   logic [31:0] m_pc;
   bit          m_skip;

   function automatic bit rvc(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

   task automatic model_cycle();
      logic        ev, er, ee, ep, werr;
      logic [31:0] ei;
      werr = fetch_err & ERR_EN;
      ev = 1'b0; er = 1'b0; ee = 1'b0; ep = 1'b0; ei = '0;
      if (branch || m_skip) begin
         er = 1'b1;
      end else if (m_q.size() != 0 && rvc(m_q[0].d)) begin
         ev = 1'b1; ei = {16'h0, m_q[0].d}; ee = m_q[0].e;
      end else if (m_q.size() != 0) begin
         ev = fetch_valid; er = out_ready;
         ei = {fetch_rdata[15:0], m_q[0].d};
         ee = m_q[0].e | werr; ep = werr & ~m_q[0].e;
      end else begin
         ev = fetch_valid; er = out_ready;
         ei = (werr || !rvc(fetch_rdata[15:0])) ? fetch_rdata : {16'h0, fetch_rdata[15:0]};
         ee = werr;
      end

      check_eq("valid", 32'(out_valid), 32'(ev));
      check_eq("fetch_ready", 32'(fetch_ready), 32'(er));
      if (ev) begin
         check_eq("instr", out_instr, ei);
         check_eq("addr", out_addr, m_pc);
         check_eq("err", 32'(out_err), 32'(ee));
         check_eq("err_plus2", 32'(out_err_plus2), 32'(ep));
      end

      if (branch) begin
         m_pc = branch_addr & ~32'd1;
         m_q.delete();
         m_skip = branch_addr[1];
      end else if (m_skip) begin
         if (fetch_valid) begin
            m_q.push_back({fetch_rdata[31:16], werr});
            m_skip = 1'b0;
         end
      end else if (ev && out_ready) begin
         if (m_q.size() != 0 && rvc(m_q[0].d)) begin
            void'(m_q.pop_front());
            m_pc = m_pc + 32'd2;
         end else if (m_q.size() != 0) begin
            void'(m_q.pop_front());
            m_q.push_back({fetch_rdata[31:16], werr});
            m_pc = m_pc + 32'd4;
         end else if (werr || !rvc(fetch_rdata[15:0])) begin
            m_pc = m_pc + 32'd4;
         end else begin
            m_q.push_back({fetch_rdata[31:16], 1'b0});
            m_pc = m_pc + 32'd2;
         end
      end
   endtask

   task automatic cyc(input logic fv, input logic [31:0] d, input logic fe,
                      input logic br, input logic [31:0] ba, input logic rdy);
      fetch_valid = fv; fetch_rdata = d; fetch_err = fe;
      branch = br; branch_addr = ba; out_ready = rdy;
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fetch_valid = 1'b1; fetch_rdata = $urandom; fetch_err = 1'b0;
      branch = 1'b0; branch_addr = '0; out_ready = 1'b1;
      @(negedge clk);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      check_eq("rst_instr", out_instr, 32'd0);
      check_eq("rst_err", 32'(out_err), 32'd0);
      check_eq("rst_err_plus2", 32'(out_err_plus2), 32'd0);
      check_eq("rst_addr", out_addr, 32'h0000_0080);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_pc = 32'h0000_0080;
      m_q.delete();
      m_skip = 1'b0;
   endtask

   function automatic logic [15:0] rand_half();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11)      h[1:0] = 2'b01;
      return h;
   endfunction

   initial begin
      rst = 1'b1;
      fetch_valid = 1'b0; fetch_rdata = '0; fetch_err = 1'b0;
      branch = 1'b0; branch_addr = '0; out_ready = 1'b0;

      do_reset();
      cyc(1, 32'h0000_0013, 0, 0, 0, 1);
      cyc(1, 32'h4501_4501, 0, 0, 0, 1);

      do_reset();
      cyc(1, 32'h4501_4501, 0, 0, 0, 1);
      cyc(1, 32'h0000_0013, 0, 0, 0, 1);
      cyc(1, 32'h0000_0013, 0, 0, 0, 1);

      do_reset();
      cyc(1, 32'h0013_4501, 0, 0, 0, 1);
      cyc(1, 32'h1234_0000, 0, 0, 0, 1);
      cyc(0, 32'h0000_0000, 0, 0, 0, 1);

      cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h0000_0102, 1);
      cyc(1, 32'h4501_ABCD, 0, 0, 0, 1);
      cyc(0, 32'h0000_0000, 0, 0, 0, 1);

      do_reset();
      cyc(1, 32'h0013_4501, 0, 0, 0, 1);
      cyc(1, 32'hABCD_0000, 1, 0, 0, 1);

      do_reset();
      cyc(1, 32'h0000_4501, 1, 0, 0, 1);
      cyc(1, 32'h0000_0013, 0, 0, 0, 1);

      do_reset();
      cyc(1, 32'h0013_4501, 0, 0, 0, 1);
      cyc(1, 32'h4501_0000, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 32'h1234_0000, 0, 0, 0, 0);
      cyc(1, 32'h1234_0000, 0, 1, 32'h0000_0200, 0);
      cyc(0, 32'h0000_0000, 0, 0, 0, 1);
      cyc(1, 32'h0000_0013, 0, 0, 0, 1);

      cyc(1, 32'h0013_1111, 0, 1, 32'hFFFF_FFFE, 1);
      cyc(1, 32'h0013_1111, 0, 0, 0, 1);
      cyc(1, 32'h0000_0000, 0, 0, 0, 1);
      cyc(0, 32'h0000_0000, 0, 0, 0, 1);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 3) != 0, {rand_half(), rand_half()},
                $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                $urandom, $urandom_range(0, 3) != 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
